// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver with a small receive FIFO.
//
// The asynchronous PS/2 clock goes through a 3-flop synchronizer. On each
// detected falling edge, one data bit is shifted into a 10-bit frame buffer.
// The 11th bit is the stop bit, and it closes the frame. A frame is
// accepted only if all three hold: the start bit is 0, the stop bit is 1,
// and parity is odd. Each accepted byte is pushed into a FIFO that the
// host drains with an active-low pop strobe. If the device clock stalls in
// the middle of a frame, the partial frame is abandoned after TIMEOUT
// cycles.
//
// Ports:
//   clk         system clock; every flop updates on its rising edge
//   rst_n       synchronous active-low reset
//   ps2_clk     asynchronous PS/2 device clock
//   ps2_data    asynchronous PS/2 device data, LSB first
//   nextdata_n  active-low pop request for the FIFO head
//   data        FIFO head byte (don't-care while ready=0)
//   ready       FIFO non-empty
//   overflow    sticky: a valid frame was dropped because the FIFO was full
//   frame_err   one-cycle pulse per rejected frame
module ps2_rx #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int unsigned PtrW      = $clog2(FIFO_DEPTH);
    localparam logic [PtrW:0] OccFull = (PtrW + 1)'(FIFO_DEPTH);
    localparam logic [15:0] IdleLimit = 16'(TIMEOUT);
    localparam logic [3:0]  LastBit   = 4'd10;

    // Synchronizer and edge detect
    logic [2:0] sync_q;
    logic       fall;

    // Frame assembly
    logic [3:0]  cnt_q,  cnt_d;
    logic [9:0]  buf_q,  buf_d;
    logic [15:0] idle_q, idle_d;
    logic        frame_done;
    logic        frame_ok;

    // FIFO state
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [PtrW:0]   occ_q,  occ_d;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;

    // Status flags
    logic ovf_q,  ovf_d;
    logic ferr_q, ferr_d;

    // ------------------------------------------------------------------
    // Synchronizer: sync_q[0] is the newest sample, sync_q[2] the oldest.
    // The two oldest flops are used for edge detection. This gives
    // metastability settling time on sync_q[0] before the value is used.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], ps2_clk};
        end
    end

    assign fall = sync_q[2] & ~sync_q[1];

    // ------------------------------------------------------------------
    // Frame evaluation. The stop bit is never stored: it is judged
    // directly from the sample taken at count 10.
    // ------------------------------------------------------------------
    always_comb begin
        frame_done = fall && (cnt_q == LastBit);
        frame_ok   = ~buf_q[0] & ps2_data & (^buf_q[9:1]);
    end

    // Bit counter, frame buffer and idle timeout
    always_comb begin
        cnt_d  = cnt_q;
        buf_d  = buf_q;
        idle_d = idle_q;
        if (fall) begin
            idle_d = '0;
            if (cnt_q == LastBit) begin
                cnt_d = '0;
            end else begin
                for (int i = 0; i < 10; i++) begin
                    if (cnt_q == 4'(i)) begin
                        buf_d[i] = ps2_data;
                    end
                end
                cnt_d = cnt_q + 4'd1;
            end
        end else if (cnt_q != '0) begin
            // A stalled device abandons the frame quietly (no frame_err).
            if (idle_q == IdleLimit) begin
                cnt_d  = '0;
                idle_d = '0;
            end else begin
                idle_d = idle_q + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO control. A pop is honoured only when the FIFO is non-empty.
    // Because of this, a write that arrives at the same time as a pop on
    // an empty FIFO simply performs the write. On a full FIFO, a
    // concurrent pop frees the slot that the write is about to fill.
    // ------------------------------------------------------------------
    always_comb begin
        full = (occ_q == OccFull);
        pop  = ~nextdata_n & (occ_q != '0);
        push = frame_done & frame_ok & (~full | pop);
        drop = frame_done & frame_ok & full & ~pop;

        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        if (push) begin
            wptr_d = wptr_q + PtrW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + (PtrW + 1)'(1);
            2'b01:   occ_d = occ_q - (PtrW + 1)'(1);
            default: occ_d = occ_q;
        endcase

        ovf_d  = ovf_q | drop;
        ferr_d = frame_done & ~frame_ok;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            buf_q  <= '0;
            idle_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
            ovf_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            buf_q  <= buf_d;
            idle_q <= idle_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
            ovf_q  <= ovf_d;
            ferr_q <= ferr_d;
        end
    end

    // FIFO storage needs no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= buf_q[8:1];
        end
    end

    assign data      = mem[rptr_q];
    assign ready     = (occ_q != '0);
    assign overflow  = ovf_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_ps2_rx.sv
module tb_ps2_rx;

    localparam int unsigned Depth   = 8;
    localparam int unsigned Timeout = 300;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    int n_vec = 0;
    int n_bad = 0;
    int err_cycles = 0;

    ps2_rx #(
        .FIFO_DEPTH(Depth),
        .TIMEOUT   (Timeout)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .nextdata_n(nextdata_n),
        .data      (data),
        .ready     (ready),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Count the cycles during which frame_err is high, sampled away from the
    // active clock edge. One rejected frame must give exactly one cycle.
    always @(negedge clk) begin
        if (frame_err) err_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Build an 11-bit frame: start 0, data LSB first, odd parity, stop 1.
    // Setting flip inverts the parity bit, which makes the frame invalid.
    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic flip);
        return {1'b1, (~^b) ^ flip, b, 1'b0};
    endfunction

    // One device bit: data is set up while ps2_clk is high, and the falling
    // edge comes 4 system clocks later. The clock stays low for 4 clocks.
    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_partial(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) send_bit(f[i]);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip);
        send_partial(mk_frame(b, flip), 11);
        repeat (6) @(negedge clk);
    endtask

    task automatic pop_one();
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [10:0] f;

        repeat (3) @(negedge clk);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Frame 0x1C: ready rises three system clocks after the 11th edge.
        f = mk_frame(8'h1C, 1'b0);
        send_partial(f, 10);
        ps2_data = f[10];
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        @(negedge clk);
        check("lat_ready_c1", 32'(ready), 32'd0);
        @(negedge clk);
        check("lat_ready_c2", 32'(ready), 32'd0);
        @(negedge clk);
        check("lat_ready_c3", 32'(ready), 32'd1);
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
        check("single_data", 32'(data), 32'h1C);
        pop_one();
        check("single_ready_after_pop", 32'(ready), 32'd0);
        check("single_no_err", 32'(err_cycles), 32'd0);

        // Two frames back to back, then drained in order.
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        check("two_data0", 32'(data), 32'hF0);
        pop_one();
        check("two_ready_mid", 32'(ready), 32'd1);
        check("two_data1", 32'(data), 32'h1C);
        pop_one();
        check("two_ready_end", 32'(ready), 32'd0);

        // A parity error gives a single-cycle frame_err and no FIFO write.
        err_cycles = 0;
        send_frame(8'h1C, 1'b1);
        check("perr_pulse_cycles", 32'(err_cycles), 32'd1);
        check("perr_ready", 32'(ready), 32'd0);
        send_frame(8'h1C, 1'b0);
        check("perr_recover_ready", 32'(ready), 32'd1);
        check("perr_recover_data", 32'(data), 32'h1C);
        pop_one();

        // Abandoned partial frame, then a full frame after the timeout.
        err_cycles = 0;
        send_partial(mk_frame(8'hA5, 1'b0), 5);
        repeat (Timeout + 10) @(negedge clk);
        send_frame(8'h5A, 1'b0);
        check("tmo_ready", 32'(ready), 32'd1);
        check("tmo_data", 32'(data), 32'h5A);
        check("tmo_no_err", 32'(err_cycles), 32'd0);
        pop_one();

        // Fill beyond capacity: 8 stored, the 9th dropped, overflow sticks.
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b0);
            if (i == 8) check("ovf_before_9", 32'(overflow), 32'd0);
        end
        check("ovf_after_9", 32'(overflow), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("ovf_pop_%0d", i), 32'(data), 32'(i));
            pop_one();
        end
        check("ovf_drained", 32'(ready), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Reset in mid-frame discards the partial frame and clears overflow.
        send_partial(mk_frame(8'hFF, 1'b0), 6);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        send_frame(8'h33, 1'b0);
        check("rst_frame_data", 32'(data), 32'h33);
        pop_one();
        check("rst_only_one", 32'(ready), 32'd0);
        check("rst_overflow_end", 32'(overflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 8, receive FIFO entries (power of two, 2..16).
REQ-002 SHALL provide parameter TIMEOUT, default 50000, clk cycles without a ps2_clk falling edge before an in-progress frame is abandoned.
REQ-003 SHALL have port clk  input  1  system clock; every flop updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous reset, active-low.
REQ-005 SHALL have port ps2_clk  input  1  asynchronous PS/2 device clock.
REQ-006 SHALL have port ps2_data  input  1  asynchronous PS/2 device data, LSB first.
REQ-007 SHALL have port nextdata_n  input  1  active-low pop request for the FIFO head.
REQ-008 SHALL have port data  output  8  FIFO head byte; don't-care while ready=0.
REQ-009 SHALL have port ready  output  1  FIFO non-empty.
REQ-010 SHALL have port overflow  output  1  sticky: a valid frame was dropped because the FIFO was full.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse per rejected frame.

Function
REQ-012 SHALL pass ps2_clk through a 3-flop synchronizer; a falling edge is detected when the two oldest flops read 1 then 0, at most one edge per clk cycle.
REQ-013 SHALL sample ps2_data, unsynchronized, only in the clk cycle a falling edge is detected.
REQ-014 SHALL use a 4-bit bit counter 0..10 and a 10-bit frame buffer; samples at counts 0..9 are stored at buffer[count], then count increments.
REQ-015 SHALL, on the sample at count 10, evaluate the frame: start buffer[0]=0, stop (current sample)=1, odd parity (XOR of buffer[9:1]=1); count returns to 0 in every case.
REQ-016 SHALL, for a valid frame with FIFO not full, write buffer[8:1] at the write pointer in the same cycle as the stop sample.
REQ-017 SHALL, for a valid frame with FIFO full and no pop that cycle, discard the byte and set overflow to 1.
REQ-018 SHALL, for an invalid frame, discard it, pulse frame_err high for exactly one cycle, and leave FIFO and overflow unchanged.
REQ-019 SHALL pop one entry in each cycle where nextdata_n=0 and ready=1; nextdata_n=0 with ready=0 is ignored.
REQ-020 SHALL, when a pop and a write occur in the same cycle on a full FIFO, perform both: occupancy stays FIFO_DEPTH and overflow is not set.
REQ-021 SHALL, when a pop and a write occur on an empty FIFO, perform only the write; ready goes 1 next cycle.
REQ-022 SHALL keep occupancy in a register of width log2(FIFO_DEPTH)+1; wrap-around pointers of width log2(FIFO_DEPTH).
REQ-023 SHALL drive data combinationally from the FIFO entry at the read pointer; ready = (occupancy != 0).
REQ-024 SHALL run a 16-bit idle counter that clears on every detected edge and increments otherwise while count != 0; on reaching TIMEOUT it resets count to 0 and clears itself, without asserting frame_err.
REQ-025 SHALL keep overflow at 1 until reset; pops do not clear it.

Reset
REQ-026 SHALL, with rst_n=0 at a clk edge, set the synchronizer flops to 1, bit counter, idle counter, pointers and occupancy to 0, ready=0, overflow=0, frame_err=0, and discard any partial frame.
REQ-027 SHALL NOT require FIFO storage to be reset.
REQ-028 SHALL accept a new frame starting with the first falling edge detected after rst_n returns to 1.

Verification
REQ-029 SHALL verify: frame 0x1C (bits start 0, 0,0,1,1,1,0,0,0, parity 0, stop 1) -> ready=1 three cycles after the 11th device edge, data=0x1C; pop -> ready=0.
REQ-030 SHALL verify: frames 0xF0 (parity 1) then 0x1C with no pop -> data=0xF0, pop, data=0x1C, pop, ready=0.
REQ-031 SHALL verify: 0x1C sent with parity bit 1 -> frame_err one-cycle pulse, ready stays 0; a following valid 0x1C is received.
REQ-032 SHALL verify: 9 valid frames 0x01..0x09, no pops -> overflow=1 after frame 9; 8 pops return 0x01..0x08 in order; overflow remains 1.
REQ-033 SHALL verify: 5 bits sent, then ps2_clk held at 1 for TIMEOUT+10 cycles, then full frame 0x5A -> data=0x5A, frame_err never pulses.
REQ-034 SHALL verify: rst_n=0 for one cycle after 6 bits of a frame, then full frame 0x33 -> only 0x33 is received, overflow=0.
